// File: rtl/decode_stage_hz_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU_OP encodings (also consumed by the EX ALU control)
// and the opcode-to-control decode table.
package decode_stage_hz_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    ALU_OP_MEM    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_RTYPE  = 2'b10,
    ALU_OP_IARITH = 2'b11
  } alu_op_e;

  // Control bits that travel down the pipe into EX.
  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
    logic    beq;
    logic    bne;
    logic    jump;
  } ex_ctrl_t;

  // ID-only decode results plus the EX bundle.
  typedef struct packed {
    ex_ctrl_t ex;
    logic     reg_dst;   // 1: destination is rd, 0: rt
    logic     zero_ext;  // imm16 is zero-extended instead of sign-extended
    logic     uses_rt;   // rt is a source operand
    logic     legal;
  } id_ctrl_t;

  function automatic id_ctrl_t decode_op(input logic [5:0] op);
    id_ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.ex.alu_op    = ALU_OP_RTYPE;
        c.ex.reg_write = 1'b1;
        c.reg_dst      = 1'b1;
        c.uses_rt      = 1'b1;
        c.legal        = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        c.ex.alu_op    = ALU_OP_IARITH;
        c.ex.alu_src   = 1'b1;
        c.ex.reg_write = 1'b1;
        c.zero_ext     = (op == OP_ANDI) || (op == OP_ORI);
        c.legal        = 1'b1;
      end
      OP_LW: begin
        c.ex.alu_op     = ALU_OP_MEM;
        c.ex.alu_src    = 1'b1;
        c.ex.mem_read   = 1'b1;
        c.ex.mem_to_reg = 1'b1;
        c.ex.reg_write  = 1'b1;
        c.legal         = 1'b1;
      end
      OP_SW: begin
        c.ex.alu_op    = ALU_OP_MEM;
        c.ex.alu_src   = 1'b1;
        c.ex.mem_write = 1'b1;
        c.uses_rt      = 1'b1;
        c.legal        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        c.ex.alu_op = ALU_OP_BRANCH;
        c.ex.beq    = (op == OP_BEQ);
        c.ex.bne    = (op == OP_BNE);
        c.uses_rt   = 1'b1;
        c.legal     = 1'b1;
      end
      OP_J: begin
        c.ex.alu_op = ALU_OP_MEM;
        c.ex.jump   = 1'b1;
        c.legal     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_hz_regfile_bypass.sv
// Two-read, one-write register file with write-through on both read ports
// and synchronous clear on reset.
module decode_stage_hz_regfile_bypass
  import decode_stage_hz_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic [RA_W-1:0] rs_addr_i,
  input  logic [RA_W-1:0] rt_addr_i,
  output logic [XLEN-1:0] rs_data_o,
  output logic [XLEN-1:0] rt_data_o,
  input  logic            we_i,
  input  logic [RA_W-1:0] waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  localparam int NREGS = 2 ** RA_W;

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_ok;

  assign wr_ok = we_i && ((waddr_i != '0) || !ZERO_REG);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A same-cycle writeback is forwarded so ID never sees a stale value.
  always_comb begin
    rs_data_o = regs_q[rs_addr_i];
    if (wr_ok && (waddr_i == rs_addr_i)) rs_data_o = wdata_i;
    else if (ZERO_REG && (rs_addr_i == '0)) rs_data_o = '0;
  end

  always_comb begin
    rt_data_o = regs_q[rt_addr_i];
    if (wr_ok && (waddr_i == rt_addr_i)) rt_data_o = wdata_i;
    else if (ZERO_REG && (rt_addr_i == '0)) rt_data_o = '0;
  end

endmodule

// File: rtl/decode_stage_hz.sv
// MIPS ID stage: decode, bypassed register read, load-use stall detection and
// the ID/EX pipeline register with bubble/flush handling.
module decode_stage_hz
  import decode_stage_hz_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc4,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            stall,
  output logic            illegal,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc4,
  output logic [XLEN-1:0] ex_rs_val,
  output logic [XLEN-1:0] ex_rt_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs,
  output logic [RA_W-1:0] ex_rt,
  output logic [RA_W-1:0] ex_rd,
  output logic [5:0]      ex_funct,
  output logic [XLEN-1:0] ex_jtarget,
  output logic [1:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_reg_write,
  output logic            ex_beq,
  output logic            ex_bne,
  output logic            ex_jump
);

  // ---------------- decode ----------------
  logic [5:0]      id_opcode;
  logic [RA_W-1:0] id_rs, id_rt, id_rd, id_dst;
  logic [15:0]     id_imm16;
  id_ctrl_t        id_ctrl;
  logic [XLEN-1:0] id_imm, id_rs_val, id_rt_val, id_jtarget;

  assign id_opcode = if_instr[31:26];
  assign id_rs     = RA_W'(if_instr[25:21]);
  assign id_rt     = RA_W'(if_instr[20:16]);
  assign id_rd     = RA_W'(if_instr[15:11]);
  assign id_imm16  = if_instr[15:0];
  assign id_ctrl   = decode_op(id_opcode);
  assign illegal   = if_valid && !id_ctrl.legal;

  assign id_imm = id_ctrl.zero_ext ? {{(XLEN-16){1'b0}}, id_imm16}
                                   : {{(XLEN-16){id_imm16[15]}}, id_imm16};
  assign id_jtarget = {if_pc4[XLEN-1:28], if_instr[25:0], 2'b00};

  // A non-writing instruction reports rd=0 so EX forwarding never matches it.
  assign id_dst = !id_ctrl.ex.reg_write ? '0 : (id_ctrl.reg_dst ? id_rd : id_rt);

  decode_stage_hz_regfile_bypass #(
    .XLEN     (XLEN),
    .RA_W     (RA_W),
    .ZERO_REG (ZERO_REG)
  ) u_regfile (
    .clock_i   (clock),
    .reset_i   (reset),
    .rs_addr_i (id_rs),
    .rt_addr_i (id_rt),
    .rs_data_o (id_rs_val),
    .rt_data_o (id_rt_val),
    .we_i      (wb_we),
    .waddr_i   (wb_rd),
    .wdata_i   (wb_data)
  );

  // ---------------- ID/EX register ----------------
  logic            ex_valid_q, ex_valid_d;
  ex_ctrl_t        ex_ctrl_q, ex_ctrl_d;
  logic [XLEN-1:0] ex_pc4_q, ex_pc4_d;
  logic [XLEN-1:0] ex_rs_val_q, ex_rs_val_d;
  logic [XLEN-1:0] ex_rt_val_q, ex_rt_val_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [XLEN-1:0] ex_jtarget_q, ex_jtarget_d;
  logic [RA_W-1:0] ex_rs_q, ex_rs_d;
  logic [RA_W-1:0] ex_rt_q, ex_rt_d;
  logic [RA_W-1:0] ex_rd_q, ex_rd_d;
  logic [5:0]      ex_funct_q, ex_funct_d;

  // ---------------- hazard detection ----------------
  // The bubble clears ex_mem_read, so a load-use stall lasts exactly one cycle.
  logic src_match, bubble;

  assign src_match = (ex_rd_q == id_rs) || (id_ctrl.uses_rt && (ex_rd_q == id_rt));
  assign stall     = if_valid && ex_valid_q && ex_ctrl_q.mem_read &&
                     (ex_rd_q != '0) && !flush && src_match;
  assign bubble    = flush || stall || !if_valid;

  always_comb begin
    ex_valid_d   = 1'b0;
    ex_ctrl_d    = '0;
    ex_pc4_d     = '0;
    ex_rs_val_d  = '0;
    ex_rt_val_d  = '0;
    ex_imm_d     = '0;
    ex_jtarget_d = '0;
    ex_rs_d      = '0;
    ex_rt_d      = '0;
    ex_rd_d      = '0;
    ex_funct_d   = '0;
    if (!bubble) begin
      ex_valid_d   = 1'b1;
      ex_ctrl_d    = id_ctrl.ex;
      ex_pc4_d     = if_pc4;
      ex_rs_val_d  = id_rs_val;
      ex_rt_val_d  = id_rt_val;
      ex_imm_d     = id_imm;
      ex_jtarget_d = id_jtarget;
      ex_rs_d      = id_rs;
      ex_rt_d      = id_rt;
      ex_rd_d      = id_dst;
      ex_funct_d   = if_instr[5:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_pc4_q     <= '0;
      ex_rs_val_q  <= '0;
      ex_rt_val_q  <= '0;
      ex_imm_q     <= '0;
      ex_jtarget_q <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_funct_q   <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_pc4_q     <= ex_pc4_d;
      ex_rs_val_q  <= ex_rs_val_d;
      ex_rt_val_q  <= ex_rt_val_d;
      ex_imm_q     <= ex_imm_d;
      ex_jtarget_q <= ex_jtarget_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_funct_q   <= ex_funct_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_pc4        = ex_pc4_q;
  assign ex_rs_val     = ex_rs_val_q;
  assign ex_rt_val     = ex_rt_val_q;
  assign ex_imm        = ex_imm_q;
  assign ex_jtarget    = ex_jtarget_q;
  assign ex_rs         = ex_rs_q;
  assign ex_rt         = ex_rt_q;
  assign ex_rd         = ex_rd_q;
  assign ex_funct      = ex_funct_q;
  assign ex_alu_op     = ex_ctrl_q.alu_op;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_mem_read   = ex_ctrl_q.mem_read;
  assign ex_mem_write  = ex_ctrl_q.mem_write;
  assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign ex_reg_write  = ex_ctrl_q.reg_write;
  assign ex_beq        = ex_ctrl_q.beq;
  assign ex_bne        = ex_ctrl_q.bne;
  assign ex_jump       = ex_ctrl_q.jump;

endmodule
